// File: rtl/id_decode_stage_if.sv
// ============================================================================
//  Module      : id_decode_stage_if
//  Description : Fetch-side and execute-side handshake bundle of the decode stage.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface id_decode_stage_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic [ADDR_W-1:0] in_pc;

   logic              out_valid;
   logic              out_ready;
   logic [5:0]        out_op;
   logic [4:0]        out_rs;
   logic [4:0]        out_rt;
   logic [4:0]        out_rd;
   logic [4:0]        out_shamt;
   logic [5:0]        out_funct;
   logic [15:0]       out_imm16;
   logic [25:0]       out_target;
   logic [DATA_W-1:0] out_ext_imm;
   logic [ADDR_W-1:0] out_pc;
   logic [ADDR_W-1:0] out_br_target;
   logic [ADDR_W-1:0] out_j_target;
   logic [4:0]        out_dst;
   logic [4:0]        out_class;

   // Driver side: fetch stage plus downstream consumer.
   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_op, out_rs, out_rt, out_rd, out_shamt,
             out_funct, out_imm16, out_target, out_ext_imm, out_pc,
             out_br_target, out_j_target, out_dst, out_class
   );

   // Decode stage side.
   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_op, out_rs, out_rt, out_rd, out_shamt,
             out_funct, out_imm16, out_target, out_ext_imm, out_pc,
             out_br_target, out_j_target, out_dst, out_class
   );
endinterface

`default_nettype wire

// File: rtl/id_decode_stage.sv
// ============================================================================
//  Module      : id_decode_stage
//  Description : Registered MIPS-32 decode stage with a 2-entry skid buffer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_decode_stage #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int ZEXT_OPS = 1
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   input  wire logic          flush,
   id_decode_stage_if.slave   bus
);

   localparam logic [5:0] c_OP_RTYPE = 6'h00;
   localparam logic [5:0] c_OP_J     = 6'h02;
   localparam logic [5:0] c_OP_JAL   = 6'h03;
   localparam logic [5:0] c_OP_BEQ   = 6'h04;
   localparam logic [5:0] c_OP_BNE   = 6'h05;
   localparam logic [5:0] c_OP_ANDI  = 6'h0C;
   localparam logic [5:0] c_OP_ORI   = 6'h0D;
   localparam logic [5:0] c_OP_XORI  = 6'h0E;
   localparam logic [5:0] c_OP_LW    = 6'h23;
   localparam logic [5:0] c_OP_SW    = 6'h2B;
   localparam logic [4:0] c_REG_RA   = 5'd31;

   typedef struct packed {
      logic [5:0]        op;
      logic [4:0]        rs;
      logic [4:0]        rt;
      logic [4:0]        rd;
      logic [4:0]        shamt;
      logic [5:0]        funct;
      logic [15:0]       imm16;
      logic [25:0]       target;
      logic [DATA_W-1:0] ext_imm;
      logic [ADDR_W-1:0] pc;
      logic [ADDR_W-1:0] br_target;
      logic [ADDR_W-1:0] j_target;
      logic [4:0]        dst;
      logic [4:0]        cls;
   } rec_t;

   rec_t              w_dec;
   rec_t              r_out;
   rec_t              r_skid;
   logic              r_out_valid;
   logic              r_skid_valid;

   logic [5:0]        w_op;
   logic [15:0]       w_imm16;
   logic [ADDR_W-1:0] w_pc4;
   logic [ADDR_W-1:0] w_imm_sext;
   logic [ADDR_W-1:0] w_j_target;
   logic [DATA_W-1:0] w_ext_zero;
   logic [DATA_W-1:0] w_ext_sign;
   logic              w_zext_op;
   logic              w_accept;
   logic              w_out_free;

   assign w_op       = bus.in_instr[31:26];
   assign w_imm16    = bus.in_instr[15:0];
   assign w_pc4      = bus.in_pc + ADDR_W'(4);
   assign w_imm_sext = ADDR_W'($signed(w_imm16));
   assign w_ext_zero = DATA_W'(w_imm16);
   assign w_ext_sign = DATA_W'($signed(w_imm16));

   generate
      if (ZEXT_OPS != 0) begin : g_zext_logic
         assign w_zext_op = (w_op == c_OP_ANDI) || (w_op == c_OP_ORI) || (w_op == c_OP_XORI);
      end else begin : g_sext_only
         assign w_zext_op = 1'b0;
      end
   endgenerate

   // With a 28-bit address space the jump target carries no region bits from pc+4.
   generate
      if (ADDR_W > 28) begin : g_j_region
         assign w_j_target = {w_pc4[ADDR_W-1:28], bus.in_instr[25:0], 2'b00};
      end else begin : g_j_flat
         assign w_j_target = {bus.in_instr[25:0], 2'b00};
      end
   endgenerate

   always_comb begin
      w_dec           = '0;
      w_dec.op        = w_op;
      w_dec.rs        = bus.in_instr[25:21];
      w_dec.rt        = bus.in_instr[20:16];
      w_dec.rd        = bus.in_instr[15:11];
      w_dec.shamt     = bus.in_instr[10:6];
      w_dec.funct     = bus.in_instr[5:0];
      w_dec.imm16     = w_imm16;
      w_dec.target    = bus.in_instr[25:0];
      w_dec.ext_imm   = w_zext_op ? w_ext_zero : w_ext_sign;
      w_dec.pc        = bus.in_pc;
      w_dec.br_target = w_pc4 + (w_imm_sext << 2);
      w_dec.j_target  = w_j_target;

      if (w_op == c_OP_RTYPE) begin
         w_dec.dst = bus.in_instr[15:11];
      end else if (w_op == c_OP_JAL) begin
         w_dec.dst = c_REG_RA;
      end else begin
         w_dec.dst = bus.in_instr[20:16];
      end

      w_dec.cls = {(w_op == c_OP_RTYPE),
                   (w_op == c_OP_BEQ) || (w_op == c_OP_BNE),
                   (w_op == c_OP_J)   || (w_op == c_OP_JAL),
                   (w_op == c_OP_LW),
                   (w_op == c_OP_SW)};
   end

   assign w_accept   = bus.in_valid & ~r_skid_valid;
   assign w_out_free = ~r_out_valid | bus.out_ready;

   // The skid entry only fills while the out register is stalled, so in_ready
   // never needs to look at out_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out        <= '0;
         r_skid       <= '0;
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (flush) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (w_out_free) begin
         if (r_skid_valid) begin
            r_out        <= r_skid;
            r_out_valid  <= 1'b1;
            r_skid_valid <= 1'b0;
         end else if (w_accept) begin
            r_out        <= w_dec;
            r_out_valid  <= 1'b1;
         end else begin
            r_out_valid  <= 1'b0;
         end
      end else if (w_accept) begin
         r_skid       <= w_dec;
         r_skid_valid <= 1'b1;
      end
   end

   assign bus.in_ready      = ~r_skid_valid;
   assign bus.out_valid     = r_out_valid;
   assign bus.out_op        = r_out.op;
   assign bus.out_rs        = r_out.rs;
   assign bus.out_rt        = r_out.rt;
   assign bus.out_rd        = r_out.rd;
   assign bus.out_shamt     = r_out.shamt;
   assign bus.out_funct     = r_out.funct;
   assign bus.out_imm16     = r_out.imm16;
   assign bus.out_target    = r_out.target;
   assign bus.out_ext_imm   = r_out.ext_imm;
   assign bus.out_pc        = r_out.pc;
   assign bus.out_br_target = r_out.br_target;
   assign bus.out_j_target  = r_out.j_target;
   assign bus.out_dst       = r_out.dst;
   assign bus.out_class     = r_out.cls;

endmodule

`default_nettype wire

// File: tb/tb_id_decode_stage.sv
// ============================================================================
//  Module      : tb_id_decode_stage
//  Description : Directed and randomized self-checking bench for id_decode_stage.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_decode_stage;

   localparam int c_N_RAND   = 10000;
   localparam int c_MAX_CYC  = 80000;

   logic clk;
   logic rst_n;
   logic flush;

   id_decode_stage_if #(.DATA_W(32), .ADDR_W(32)) bus ();

   id_decode_stage #(.DATA_W(32), .ADDR_W(32), .ZEXT_OPS(1)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [5:0]  op;
      logic [4:0]  rs, rt, rd, shamt;
      logic [5:0]  funct;
      logic [15:0] imm16;
      logic [25:0] target;
      logic [31:0] ext_imm, pc, br, j;
      logic [4:0]  dst, cls;
   } exp_t;

   int   n_pass  = 0;
   int   n_total = 0;
   exp_t q[$];

   // Decoding straight from the instruction-set definition, using integer arithmetic.
   function automatic exp_t model(logic [31:0] ins, logic [31:0] pc);
      exp_t e;
      int   op = int'(ins[31:26]);
      int   s  = int'(ins[15:0]);
      if (s >= 32768) s = s - 65536;
      e.op = ins[31:26]; e.rs = ins[25:21]; e.rt = ins[20:16]; e.rd = ins[15:11];
      e.shamt = ins[10:6]; e.funct = ins[5:0]; e.imm16 = ins[15:0]; e.target = ins[25:0];
      e.pc = pc;
      if (op == 12 || op == 13 || op == 14) e.ext_imm = {16'h0000, ins[15:0]};
      else                                  e.ext_imm = 32'(s);
      e.br = pc + 32'd4 + 32'(s * 4);
      e.j  = ((pc + 32'd4) & 32'hF000_0000) | (32'(ins[25:0]) * 32'd4);
      e.dst = ins[20:16];
      e.cls = 5'b00000;
      case (op)
         0:  begin e.dst = ins[15:11]; e.cls = 5'b10000; end
         2:  e.cls = 5'b00100;
         3:  begin e.dst = 5'd31; e.cls = 5'b00100; end
         4, 5: e.cls = 5'b01000;
         35: e.cls = 5'b00010;
         43: e.cls = 5'b00001;
         default: e.cls = 5'b00000;
      endcase
      return e;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic check_out(string tag, exp_t e);
      chk({tag, ".op"},     32'(bus.out_op),        32'(e.op));
      chk({tag, ".rs"},     32'(bus.out_rs),        32'(e.rs));
      chk({tag, ".rt"},     32'(bus.out_rt),        32'(e.rt));
      chk({tag, ".rd"},     32'(bus.out_rd),        32'(e.rd));
      chk({tag, ".shamt"},  32'(bus.out_shamt),     32'(e.shamt));
      chk({tag, ".funct"},  32'(bus.out_funct),     32'(e.funct));
      chk({tag, ".imm16"},  32'(bus.out_imm16),     32'(e.imm16));
      chk({tag, ".target"}, 32'(bus.out_target),    32'(e.target));
      chk({tag, ".ext"},    bus.out_ext_imm,        e.ext_imm);
      chk({tag, ".pc"},     bus.out_pc,             e.pc);
      chk({tag, ".br"},     bus.out_br_target,      e.br);
      chk({tag, ".j"},      bus.out_j_target,       e.j);
      chk({tag, ".dst"},    32'(bus.out_dst),       32'(e.dst));
      chk({tag, ".class"},  32'(bus.out_class),     32'(e.cls));
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(logic [31:0] ins, logic [31:0] pc);
      bus.in_valid = 1'b1;
      bus.in_instr = ins;
      bus.in_pc    = pc;
      tick();
      bus.in_valid = 1'b0;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0] ops [11] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h23, 6'h2B,
                               6'h0C, 6'h0D, 6'h0E, 6'h3F};
      int         k = int'($urandom_range(0, 11));
      logic [5:0] op;
      logic [31:0] r = $urandom;
      op = (k == 11) ? r[31:26] : ops[k];
      return {op, r[25:0]};
   endfunction

   initial begin
      int   sent;
      int   cyc;
      exp_t e;
      exp_t ea;
      exp_t eb;

      rst_n         = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_instr  = '0;
      bus.in_pc     = '0;
      bus.out_ready = 1'b0;
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst.in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst.out_pc",    bus.out_pc,         32'd0);
      chk("rst.out_dst",   32'(bus.out_dst),   32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // lw with negative offset
      bus.out_ready = 1'b1;
      send(32'h8C22_FFFC, 32'h0040_0010);
      chk("lw.valid", 32'(bus.out_valid), 32'd1);
      check_out("lw", model(32'h8C22_FFFC, 32'h0040_0010));
      chk("lw.spec_ext", bus.out_ext_imm,     32'hFFFF_FFFC);
      chk("lw.spec_br",  bus.out_br_target,   32'h0040_0004);
      chk("lw.spec_cls", 32'(bus.out_class),  32'h0000_0002);

      send(32'h0C10_0004, 32'h0040_0000);
      check_out("jal", model(32'h0C10_0004, 32'h0040_0000));
      chk("jal.spec_j",   bus.out_j_target,   32'h0040_0010);
      chk("jal.spec_dst", 32'(bus.out_dst),   32'd31);

      send(32'h3421_F000, 32'h0040_0004);
      check_out("ori", model(32'h3421_F000, 32'h0040_0004));
      chk("ori.spec_ext", bus.out_ext_imm, 32'h0000_F000);
      tick();
      chk("idle.out_valid", 32'(bus.out_valid), 32'd0);

      // Back-pressure: A into out, B into skid.
      bus.out_ready = 1'b0;
      ea = model(32'h1022_0010, 32'hFFFF_FFF8);
      eb = model(32'h0085_1820, 32'h0000_1000);
      send(32'h1022_0010, 32'hFFFF_FFF8);
      send(32'h0085_1820, 32'h0000_1000);
      chk("bp.in_ready_low", 32'(bus.in_ready), 32'd0);
      check_out("bp.hold_a", ea);
      bus.out_ready = 1'b1;
      tick();
      chk("bp.b_valid", 32'(bus.out_valid), 32'd1);
      check_out("bp.b", eb);
      chk("bp.in_ready_back", 32'(bus.in_ready), 32'd1);
      tick();
      chk("bp.drained", 32'(bus.out_valid), 32'd0);

      // Flush with out and skid full and an input offered.
      bus.out_ready = 1'b0;
      send(32'hAC41_0008, 32'h0000_2000);
      send(32'h0800_0123, 32'h0000_2004);
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h1400_FFFF;
      bus.in_pc    = 32'h0000_2008;
      flush        = 1'b1;
      tick();
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      chk("fl.out_valid", 32'(bus.out_valid), 32'd0);
      chk("fl.in_ready",  32'(bus.in_ready),  32'd1);
      // Flush against an accept into an empty stage.
      bus.in_valid = 1'b1;
      flush        = 1'b1;
      tick();
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      chk("fl2.out_valid", 32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'b1;
      tick();
      chk("fl.no_ghost", 32'(bus.out_valid), 32'd0);
      send(32'h2402_0007, 32'h0000_3000);
      check_out("fl.next", model(32'h2402_0007, 32'h0000_3000));
      tick();

      // Reset mid-stream with both entries occupied.
      bus.out_ready = 1'b0;
      send(32'h8C22_0004, 32'h0000_4000);
      send(32'h8C22_0008, 32'h0000_4004);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst.out_valid", 32'(bus.out_valid), 32'd0);
      chk("mrst.in_ready",  32'(bus.in_ready),  32'd1);
      chk("mrst.out_pc",    bus.out_pc,         32'd0);
      chk("mrst.out_op",    32'(bus.out_op),    32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Random traffic against the scoreboard.
      sent = 0;
      cyc  = 0;
      q.delete();
      while ((sent < c_N_RAND || q.size() > 0) && cyc < c_MAX_CYC) begin
         chk("rnd.out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
         chk("rnd.in_ready",  32'(bus.in_ready),  32'(q.size() < 2));
         bus.in_valid  = (sent < c_N_RAND) && ($urandom_range(0, 99) < 60);
         bus.in_instr  = rand_instr();
         bus.in_pc     = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                     : $urandom;
         bus.out_ready = ($urandom_range(0, 99) < 60);
         if (bus.out_valid && bus.out_ready && q.size() > 0) begin
            e = q.pop_front();
            check_out("rnd", e);
         end
         if (bus.in_valid && bus.in_ready) begin
            q.push_back(model(bus.in_instr, bus.in_pc));
            sent++;
         end
         tick();
         cyc++;
      end
      bus.in_valid = 1'b0;
      chk("rnd.timeout",  32'(cyc < c_MAX_CYC), 32'd1);
      chk("rnd.all_sent", 32'(sent),           32'(c_N_RAND));
      chk("rnd.q_empty",  32'(q.size()),       32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
